// File: rtl/regfile_bypass_sb_if.sv
// Decode/writeback bundle for regfile_bypass_sb: two write ports, pending marks,
// packed read addresses and the read data/busy results.
interface regfile_bypass_sb_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned NUM_READ   = 2
);
   logic                           ctrl_writeEnableA;
   logic [ADDR_WIDTH-1:0]          ctrl_writeRegA;
   logic [DATA_WIDTH-1:0]          data_writeRegA;
   logic                           ctrl_writeEnableB;
   logic [ADDR_WIDTH-1:0]          ctrl_writeRegB;
   logic [DATA_WIDTH-1:0]          data_writeRegB;
   logic                           ctrl_pendSet;
   logic [ADDR_WIDTH-1:0]          ctrl_pendReg;
   logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg;
   logic [NUM_READ*DATA_WIDTH-1:0] data_readReg;
   logic [NUM_READ-1:0]            ctrl_readBusy;
   logic                           ctrl_anyPending;

   modport master (
      output ctrl_writeEnableA, ctrl_writeRegA, data_writeRegA,
      output ctrl_writeEnableB, ctrl_writeRegB, data_writeRegB,
      output ctrl_pendSet, ctrl_pendReg, ctrl_readReg,
      input  data_readReg, ctrl_readBusy, ctrl_anyPending
   );

   modport slave (
      input  ctrl_writeEnableA, ctrl_writeRegA, data_writeRegA,
      input  ctrl_writeEnableB, ctrl_writeRegB, data_writeRegB,
      input  ctrl_pendSet, ctrl_pendReg, ctrl_readReg,
      output data_readReg, ctrl_readBusy, ctrl_anyPending
   );
endinterface

// File: rtl/regfile_bypass_sb.sv
// Register file with two prioritised write ports, write-first read bypass and a
// per-register pending scoreboard for load-use hazard detection.
module regfile_bypass_sb #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned NUM_READ   = 2,
   parameter int unsigned ZERO_REG   = 1
) (
   input logic                clock,
   input logic                ctrl_reset,
   regfile_bypass_sb_if.slave bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_regs [DEPTH];
   logic [DEPTH-1:0]      r_pend;
   logic [DEPTH-1:0]      w_pend_d;
   logic                  w_wr_a;
   logic                  w_wr_b;

   assign w_wr_a = bus.ctrl_writeEnableA &&
                   !((ZERO_REG != 0) && (bus.ctrl_writeRegA == '0));
   assign w_wr_b = bus.ctrl_writeEnableB &&
                   !((ZERO_REG != 0) && (bus.ctrl_writeRegB == '0));

   // Set is applied after clear so back-to-back loads keep the bit pending.
   always_comb begin
      w_pend_d = r_pend;
      if (bus.ctrl_writeEnableB) w_pend_d[bus.ctrl_writeRegB] = 1'b0;
      if (bus.ctrl_pendSet)      w_pend_d[bus.ctrl_pendReg]   = 1'b1;
      if (ZERO_REG != 0)         w_pend_d[0]                  = 1'b0;
   end

   // Port B is written last so it overrides port A on an address collision.
   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_regs[i] <= '0;
         r_pend <= '0;
      end else begin
         if (w_wr_a) r_regs[bus.ctrl_writeRegA] <= bus.data_writeRegA;
         if (w_wr_b) r_regs[bus.ctrl_writeRegB] <= bus.data_writeRegB;
         r_pend <= w_pend_d;
      end
   end

   assign bus.ctrl_anyPending = |r_pend;

   for (genvar g = 0; g < NUM_READ; g++) begin : g_read
      logic [ADDR_WIDTH-1:0] w_addr;
      logic [DATA_WIDTH-1:0] w_data;
      logic                  w_zero;
      logic                  w_hit_a;
      logic                  w_hit_b;

      assign w_addr  = bus.ctrl_readReg[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_zero  = (ZERO_REG != 0) && (w_addr == '0);
      assign w_hit_a = bus.ctrl_writeEnableA && (bus.ctrl_writeRegA == w_addr);
      assign w_hit_b = bus.ctrl_writeEnableB && (bus.ctrl_writeRegB == w_addr);

      // Reset forces zero even when a write is presented, since that write is dropped.
      always_comb begin
         w_data = r_regs[w_addr];
         if (ctrl_reset || w_zero) w_data = '0;
         else if (w_hit_b)         w_data = bus.data_writeRegB;
         else if (w_hit_a)         w_data = bus.data_writeRegA;
      end

      assign bus.data_readReg[g*DATA_WIDTH +: DATA_WIDTH] = w_data;
      assign bus.ctrl_readBusy[g] = !ctrl_reset && r_pend[w_addr] && !w_hit_b;
   end
endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Bench for regfile_bypass_sb: directed vector table, reset and parametrisation
// sequences, and randomized traffic against an array-based reference model.
module tb_regfile_bypass_sb;
   localparam int unsigned DW0 = 32, AW0 = 5, NR0 = 2;
   localparam int unsigned DW1 = 16, AW1 = 3, NR1 = 4;

   logic clock = 1'b0;
   logic ctrl_reset;
   always #5 clock = ~clock;

   regfile_bypass_sb_if #(.DATA_WIDTH(DW0), .ADDR_WIDTH(AW0), .NUM_READ(NR0)) bus0 ();
   regfile_bypass_sb_if #(.DATA_WIDTH(DW1), .ADDR_WIDTH(AW1), .NUM_READ(NR1)) bus1 ();

   regfile_bypass_sb #(.DATA_WIDTH(DW0), .ADDR_WIDTH(AW0), .NUM_READ(NR0), .ZERO_REG(1)) dut0 (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .bus        (bus0)
   );
   regfile_bypass_sb #(.DATA_WIDTH(DW1), .ADDR_WIDTH(AW1), .NUM_READ(NR1), .ZERO_REG(0)) dut1 (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .bus        (bus1)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        we_a; logic [4:0] wr_a; logic [31:0] d_a;
      logic        we_b; logic [4:0] wr_b; logic [31:0] d_b;
      logic        ps;   logic [4:0] pr;
      logic [4:0]  ra0;  logic [4:0] ra1;
      logic [31:0] e0;   logic [31:0] e1; logic [1:0] eb; logic ea;
   } vec_t;

   // Reference model for dut0 (ZERO_REG=1): plain arrays updated in program order.
   logic [31:0] m_reg [32];
   logic        m_pend [32];

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (bus0.ctrl_writeEnableB && bus0.ctrl_writeRegB == a) return bus0.data_writeRegB;
      if (bus0.ctrl_writeEnableA && bus0.ctrl_writeRegA == a) return bus0.data_writeRegA;
      return m_reg[a];
   endfunction

   function automatic logic m_busy(input logic [4:0] a);
      return m_pend[a] && !(bus0.ctrl_writeEnableB && bus0.ctrl_writeRegB == a);
   endfunction

   function automatic logic m_any();
      logic any = 1'b0;
      for (int i = 0; i < 32; i++) any |= m_pend[i];
      return any;
   endfunction

   task automatic m_edge();
      if (bus0.ctrl_writeEnableA && bus0.ctrl_writeRegA != 0)
         m_reg[bus0.ctrl_writeRegA] = bus0.data_writeRegA;
      if (bus0.ctrl_writeEnableB && bus0.ctrl_writeRegB != 0)
         m_reg[bus0.ctrl_writeRegB] = bus0.data_writeRegB;
      if (bus0.ctrl_writeEnableB) m_pend[bus0.ctrl_writeRegB] = 1'b0;
      if (bus0.ctrl_pendSet && bus0.ctrl_pendReg != 0) m_pend[bus0.ctrl_pendReg] = 1'b1;
   endtask

   task automatic drive0(input logic we_a, input logic [4:0] wr_a, input logic [31:0] d_a,
                         input logic we_b, input logic [4:0] wr_b, input logic [31:0] d_b,
                         input logic ps, input logic [4:0] pr,
                         input logic [4:0] ra0, input logic [4:0] ra1);
      bus0.ctrl_writeEnableA = we_a; bus0.ctrl_writeRegA = wr_a; bus0.data_writeRegA = d_a;
      bus0.ctrl_writeEnableB = we_b; bus0.ctrl_writeRegB = wr_b; bus0.data_writeRegB = d_b;
      bus0.ctrl_pendSet = ps; bus0.ctrl_pendReg = pr;
      bus0.ctrl_readReg = {ra1, ra0};
   endtask

   task automatic idle1();
      bus1.ctrl_writeEnableA = 1'b0; bus1.ctrl_writeRegA = '0; bus1.data_writeRegA = '0;
      bus1.ctrl_writeEnableB = 1'b0; bus1.ctrl_writeRegB = '0; bus1.data_writeRegB = '0;
      bus1.ctrl_pendSet = 1'b0; bus1.ctrl_pendReg = '0; bus1.ctrl_readReg = '0;
   endtask

   task automatic check0(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [1:0] eb, input logic ea);
      check({tag, ".rd0"}, 64'(bus0.data_readReg[31:0]), 64'(e0));
      check({tag, ".rd1"}, 64'(bus0.data_readReg[63:32]), 64'(e1));
      check({tag, ".busy"}, 64'(bus0.ctrl_readBusy), 64'(eb));
      check({tag, ".any"}, 64'(bus0.ctrl_anyPending), 64'(ea));
   endtask

   function automatic logic [15:0] v1(input int i);
      return (i == 0) ? 16'hFFFF : 16'(16'h1111 * i);
   endfunction

   vec_t tbl [14];

   initial begin
      //          weA rA  dA            weB rB  dB            ps pr  ra0 ra1  e0            e1            eb     ea
      tbl[0]  = '{0, 0, 32'h0,        0, 0, 32'h0,        1, 3,  3, 0,  32'h0,        32'h0,        2'b00, 0};
      tbl[1]  = '{1, 3, 32'h11,       0, 0, 32'h0,        0, 0,  3, 3,  32'h11,       32'h11,       2'b11, 1};
      tbl[2]  = '{0, 0, 32'h0,        1, 3, 32'h55,       0, 0,  3, 4,  32'h55,       32'h0,        2'b00, 1};
      tbl[3]  = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  3, 3,  32'h55,       32'h55,       2'b00, 0};
      tbl[4]  = '{1, 7, 32'hAAAA0000, 1, 7, 32'h0000BBBB, 0, 0,  7, 3,  32'h0000BBBB, 32'h55,       2'b00, 0};
      tbl[5]  = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  7, 7,  32'h0000BBBB, 32'h0000BBBB, 2'b00, 0};
      tbl[6]  = '{1, 0, 32'hFFFFFFFF, 0, 0, 32'h0,        1, 0,  0, 7,  32'h0,        32'h0000BBBB, 2'b00, 0};
      tbl[7]  = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  0, 0,  32'h0,        32'h0,        2'b00, 0};
      tbl[8]  = '{0, 0, 32'h0,        0, 0, 32'h0,        1, 9,  9, 9,  32'h0,        32'h0,        2'b00, 0};
      tbl[9]  = '{0, 0, 32'h0,        1, 9, 32'h1,        1, 9,  9, 9,  32'h1,        32'h1,        2'b00, 1};
      tbl[10] = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  9, 9,  32'h1,        32'h1,        2'b11, 1};
      tbl[11] = '{0, 0, 32'h0,        0, 0, 32'h0,        1, 9,  9, 9,  32'h1,        32'h1,        2'b11, 1};
      tbl[12] = '{0, 0, 32'h0,        1, 9, 32'h2,        0, 0,  9, 0,  32'h2,        32'h0,        2'b00, 1};
      tbl[13] = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  9, 9,  32'h2,        32'h2,        2'b00, 0};

      ctrl_reset = 1'b1;
      drive0(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle1();
      repeat (2) @(posedge clock);
      #1 ctrl_reset = 1'b0;
      #1 check0("reset", 32'h0, 32'h0, 2'b00, 1'b0);
      @(posedge clock); #1;

      for (int i = 0; i < 14; i++) begin
         drive0(tbl[i].we_a, tbl[i].wr_a, tbl[i].d_a, tbl[i].we_b, tbl[i].wr_b, tbl[i].d_b,
                tbl[i].ps, tbl[i].pr, tbl[i].ra0, tbl[i].ra1);
         #3 check0($sformatf("tbl%0d", i), tbl[i].e0, tbl[i].e1, tbl[i].eb, tbl[i].ea);
         @(posedge clock); #1;
      end

      // Reset asserted between edges must clear state and outputs immediately.
      drive0(1, 5, 32'h12345678, 0, 0, 0, 1, 5, 5, 5);
      @(posedge clock); #1;
      drive0(0, 0, 0, 0, 0, 0, 0, 0, 5, 5);
      #2 check0("pre_rst", 32'h12345678, 32'h12345678, 2'b11, 1'b1);
      #1 ctrl_reset = 1'b1;
      drive0(0, 0, 0, 1, 5, 32'hDEAD, 1, 5, 5, 5);
      #1 check0("in_rst", 32'h0, 32'h0, 2'b00, 1'b0);
      @(posedge clock); #1;
      check0("in_rst_edge", 32'h0, 32'h0, 2'b00, 1'b0);
      drive0(0, 0, 0, 0, 0, 0, 0, 0, 5, 5);
      ctrl_reset = 1'b0;
      #1 check0("post_rst", 32'h0, 32'h0, 2'b00, 1'b0);
      @(posedge clock); #1;
      check0("post_rst_edge", 32'h0, 32'h0, 2'b00, 1'b0);

      for (int i = 0; i < 32; i++) begin
         m_reg[i] = '0;
         m_pend[i] = 1'b0;
      end
      for (int n = 0; n < 500; n++) begin
         logic [4:0] ra0, ra1;
         ra0 = 5'($urandom_range(0, 7));
         ra1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         drive0(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), ra0, ra1);
         #3;
         check0($sformatf("rnd%0d", n), m_read(ra0), m_read(ra1),
                {m_busy(ra1), m_busy(ra0)}, m_any());
         m_edge();
         @(posedge clock); #1;
      end
      drive0(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Narrow 4-read-port instance without a hardwired zero register.
      for (int k = 0; k < 4; k++) begin
         bus1.ctrl_writeEnableA = 1'b1; bus1.ctrl_writeRegA = 3'(2 * k);
         bus1.data_writeRegA = v1(2 * k);
         bus1.ctrl_writeEnableB = 1'b1; bus1.ctrl_writeRegB = 3'(2 * k + 1);
         bus1.data_writeRegB = v1(2 * k + 1);
         bus1.ctrl_pendSet = (k == 0); bus1.ctrl_pendReg = 3'd0;
         @(posedge clock); #1;
      end
      idle1();
      for (int s = 0; s < 3; s++) begin
         logic [2:0] a [4];
         logic [3:0] eb;
         case (s)
            0:       begin a[0] = 0; a[1] = 1; a[2] = 2; a[3] = 3; eb = 4'b0001; end
            1:       begin a[0] = 4; a[1] = 5; a[2] = 6; a[3] = 7; eb = 4'b0000; end
            default: begin a[0] = 7; a[1] = 0; a[2] = 7; a[3] = 3; eb = 4'b0010; end
         endcase
         bus1.ctrl_readReg = {a[3], a[2], a[1], a[0]};
         #2;
         for (int p = 0; p < 4; p++)
            check($sformatf("p16.set%0d.port%0d", s, p),
                  64'(bus1.data_readReg[p*16 +: 16]), 64'(v1(int'(a[p]))));
         check($sformatf("p16.set%0d.busy", s), 64'(bus1.ctrl_readBusy), 64'(eb));
         check($sformatf("p16.set%0d.any", s), 64'(bus1.ctrl_anyPending), 64'(1'b1));
         @(posedge clock); #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
